// File: rtl/frame_drain_ctrl_if.sv
// Bundle of descriptor, packet-memory and transmit signals for frame_drain_ctrl.
// master is the controller side; slave is the environment side.
interface frame_drain_ctrl_if #(
    parameter int pADDR_W = 11
);
    logic               i_desc_empty;
    logic [pADDR_W-1:0] i_desc_addr;
    logic [10:0]        i_desc_len;
    logic               o_desc_rd;
    logic               o_mem_rd;
    logic [pADDR_W-1:0] o_mem_addr;
    logic [7:0]         i_mem_data;
    logic               i_pause;
    logic               o_tx_en;
    logic [7:0]         o_tx_d;
    logic               o_busy;
    logic [15:0]        o_frame_cnt;
    logic [15:0]        o_drop_cnt;

    modport master (
        input  i_desc_empty, i_desc_addr, i_desc_len, i_mem_data, i_pause,
        output o_desc_rd, o_mem_rd, o_mem_addr, o_tx_en, o_tx_d, o_busy,
        output o_frame_cnt, o_drop_cnt
    );

    modport slave (
        output i_desc_empty, i_desc_addr, i_desc_len, i_mem_data, i_pause,
        input  o_desc_rd, o_mem_rd, o_mem_addr, o_tx_en, o_tx_d, o_busy,
        input  o_frame_cnt, o_drop_cnt
    );
endinterface

// File: rtl/frame_drain_ctrl.sv
// Pops frame descriptors, streams the frame bytes out of packet memory onto a
// GMII-style byte bus, and enforces an inter-frame gap between frames.
module frame_drain_ctrl #(
    parameter int pADDR_W  = 11,
    parameter int pMAX_LEN = 1518,
    parameter int pIFG     = 12
) (
    input  logic                iclk,
    input  logic                i_rst,
    frame_drain_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GAP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [pADDR_W-1:0] addr_q;
    logic [10:0]        rem_q;
    logic [15:0]        gap_q;
    logic               rd_d1;
    logic               last_d1;
    logic               tx_en_q;
    logic [7:0]         tx_d_q;
    logic [15:0]        frame_q;
    logic [15:0]        drop_q;

    logic               pop;
    logic               legal;
    logic               mem_rd;
    logic               last_rd;
    logic               gap_done;

    always_ff @(posedge iclk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        legal     = (bus.i_desc_len != 11'd0) &&
                    (int'(bus.i_desc_len) <= pMAX_LEN);
        mem_rd    = (state == READ);
        last_rd   = mem_rd && (rem_q == 11'd1);
        gap_done  = (gap_q == 16'(pIFG - 1));
        unique case (state)
            IDLE: begin
                if (!bus.i_desc_empty && !bus.i_pause) begin
                    pop = 1'b1;
                    if (legal) state_nxt = READ;
                end
            end
            READ: begin
                if (last_rd) state_nxt = (pIFG == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A pop during reset would silently lose a descriptor
        if (i_rst) pop = 1'b0;
    end

    always_ff @(posedge iclk) begin
        if (i_rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            rd_d1   <= 1'b0;
            last_d1 <= 1'b0;
            tx_en_q <= 1'b0;
            tx_d_q  <= '0;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            rd_d1   <= mem_rd;
            last_d1 <= last_rd;
            tx_en_q <= rd_d1;
            tx_d_q  <= rd_d1 ? bus.i_mem_data : 8'h00;
            // Counts on the edge that puts the last byte on the bus
            if (last_d1) frame_q <= frame_q + 16'd1;
            if (pop) begin
                addr_q <= bus.i_desc_addr;
                rem_q  <= bus.i_desc_len;
                if (!legal) drop_q <= drop_q + 16'd1;
            end else if (mem_rd) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 11'd1;
            end
            gap_q <= (state == GAP) ? gap_q + 16'd1 : 16'd0;
        end
    end

    assign bus.o_desc_rd   = pop;
    assign bus.o_mem_rd    = mem_rd;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_tx_en     = tx_en_q;
    assign bus.o_tx_d      = tx_d_q;
    assign bus.o_busy      = (state != IDLE) || rd_d1;
    assign bus.o_frame_cnt = frame_q;
    assign bus.o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_frame_drain_ctrl.sv
// Scoreboard bench for frame_drain_ctrl: directed descriptors, queued
// expected addresses/bytes, and a negedge monitor that pops and compares.
module tb_frame_drain_ctrl;

    logic iclk;
    logic i_rst;

    frame_drain_ctrl_if #(.pADDR_W(11)) bus ();

    frame_drain_ctrl #(
        .pADDR_W (11),
        .pMAX_LEN(1518),
        .pIFG    (12)
    ) dut (
        .iclk (iclk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct packed {
        logic [10:0] a;
        logic [10:0] l;
    } desc_t;

    typedef struct packed {
        logic [7:0]  d;
        logic        last;
        logic [15:0] fc;
    } exp_t;

    desc_t       dq[$];
    exp_t        bq[$];
    logic [10:0] aq[$];

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;
    int idle_run = 0;
    int last_gap = 0;
    int bytes_seen = 0;
    int pops = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [10:0] a);
        logic [10:0] t;
        t = a - 11'h010;
        return t[7:0];
    endfunction

    task automatic push_frame(input logic [10:0] addr, input int len);
        exp_t e;
        exp_frames++;
        dq.push_back({addr, 11'(len)});
        for (int k = 0; k < len; k++) begin
            aq.push_back(addr + 11'(k));
            e.d    = mem_byte(addr + 11'(k));
            e.last = (k == len - 1);
            e.fc   = 16'(exp_frames);
            bq.push_back(e);
        end
    endtask

    task automatic push_bad(input logic [10:0] addr, input int len);
        dq.push_back({addr, 11'(len)});
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(posedge iclk);
            #1;
            n++;
        end while (!(dq.size() == 0 && !bus.o_busy && !bus.o_tx_en &&
                     bq.size() == 0) && n < 3000);
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
        chk({name, "_left"}, bq.size() + aq.size(), 0);
    endtask

    // Descriptor FIFO model (show-ahead)
    initial begin
        logic take;
        bus.i_desc_empty = 1'b1;
        bus.i_desc_addr  = '0;
        bus.i_desc_len   = '0;
        forever begin
            @(negedge iclk);
            take = bus.o_desc_rd;
            @(posedge iclk);
            #1;
            if (take && dq.size() > 0) void'(dq.pop_front());
            bus.i_desc_empty = (dq.size() == 0);
            if (dq.size() > 0) begin
                bus.i_desc_addr = dq[0].a;
                bus.i_desc_len  = dq[0].l;
            end else begin
                bus.i_desc_addr = '0;
                bus.i_desc_len  = '0;
            end
        end
    end

    // Packet memory model: one-cycle read latency
    initial begin
        logic        rd;
        logic [10:0] ad;
        bus.i_mem_data = '0;
        forever begin
            @(negedge iclk);
            rd = bus.o_mem_rd;
            ad = bus.o_mem_addr;
            @(posedge iclk);
            #1;
            bus.i_mem_data = rd ? mem_byte(ad) : 8'h00;
        end
    end

    // Monitor
    always @(negedge iclk) begin
        exp_t        e;
        logic [10:0] a;
        if (!i_rst) begin
            if (bus.o_desc_rd) pops++;
            if (bus.o_mem_rd) begin
                if (aq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_rd_unexpected actual=%0h required=none",
                             bus.o_mem_addr);
                end else begin
                    a = aq.pop_front();
                    chk("mem_addr", bus.o_mem_addr, a);
                end
            end
            if (bus.o_tx_en) begin
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
                if (bq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none",
                             bus.o_tx_d);
                end else begin
                    e = bq.pop_front();
                    chk("tx_d", bus.o_tx_d, e.d);
                    bytes_seen++;
                    if (e.last) begin
                        chk("frame_cnt_at_last", bus.o_frame_cnt, e.fc);
                        bytes_seen = 0;
                    end
                end
            end else begin
                idle_run++;
                chk("tx_d_idle_zero", bus.o_tx_d, 0);
            end
        end
    end

    initial begin
        int n;
        i_rst       = 1'b1;
        bus.i_pause = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        chk("rst_desc_rd", bus.o_desc_rd, 0);
        chk("rst_mem_rd", bus.o_mem_rd, 0);
        chk("rst_tx_en", bus.o_tx_en, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_tx_d", bus.o_tx_d, 0);
        chk("rst_mem_addr", bus.o_mem_addr, 0);
        chk("rst_frame_cnt", bus.o_frame_cnt, 0);
        chk("rst_drop_cnt", bus.o_drop_cnt, 0);
        i_rst = 1'b0;
        repeat (2) @(posedge iclk);
        #1;

        // Single 64-byte frame, bytes 0x00..0x3F
        push_frame(11'h010, 64);
        wait_done("frame64");
        chk("frame64_cnt", bus.o_frame_cnt, 1);
        chk("frame64_pops", pops, 1);

        // Back-to-back frames: pIFG+1 idle cycles
        push_frame(11'h100, 60);
        push_frame(11'h180, 60);
        wait_done("b2b");
        chk("b2b_gap", last_gap, 13);
        chk("b2b_cnt", bus.o_frame_cnt, 3);

        // Address wrap 0x7FE,0x7FF,0x000,0x001
        push_frame(11'h7FE, 4);
        wait_done("wrap");
        chk("wrap_cnt", bus.o_frame_cnt, 4);
        chk("wrap_last_addr", bus.o_mem_addr, 11'h002);

        // Illegal lengths dropped, legal one sent
        push_bad(11'h040, 0);
        push_bad(11'h040, 1600);
        push_frame(11'h300, 60);
        wait_done("drop");
        chk("drop_cnt", bus.o_drop_cnt, 2);
        chk("drop_frame_cnt", bus.o_frame_cnt, 5);
        chk("drop_pops", pops, 7);

        // Pause blocks pop; pause mid-frame does not cut the frame
        bus.i_pause = 1'b1;
        push_frame(11'h400, 30);
        repeat (10) @(posedge iclk);
        #1;
        chk("pause_no_pop", dq.size(), 1);
        chk("pause_busy", bus.o_busy, 0);
        bus.i_pause = 1'b0;
        n = 0;
        while (!bus.o_tx_en && n < 100) begin
            @(posedge iclk);
            #1;
            n++;
        end
        chk("pause_started", bus.o_tx_en, 1);
        bus.i_pause = 1'b1;
        wait_done("pause_mid");
        chk("pause_frame_cnt", bus.o_frame_cnt, 6);
        bus.i_pause = 1'b0;

        // Reset around byte 20 of a 100-byte frame
        push_frame(11'h200, 100);
        n = 0;
        while (bytes_seen < 20 && n < 200) begin
            @(posedge iclk);
            #1;
            n++;
        end
        chk("mid_reached_20", bytes_seen, 20);
        i_rst = 1'b1;
        @(posedge iclk);
        #1;
        chk("mid_tx_en", bus.o_tx_en, 0);
        chk("mid_mem_rd", bus.o_mem_rd, 0);
        chk("mid_busy", bus.o_busy, 0);
        chk("mid_frame_cnt", bus.o_frame_cnt, 0);
        chk("mid_drop_cnt", bus.o_drop_cnt, 0);
        bq.delete();
        aq.delete();
        dq.delete();
        exp_frames = 0;
        bytes_seen = 0;
        i_rst = 1'b0;
        @(posedge iclk);
        #1;
        push_frame(11'h020, 10);
        wait_done("after_rst");
        chk("after_rst_cnt", bus.o_frame_cnt, 1);
        chk("after_rst_drop", bus.o_drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_drain_ctrl.md
FRAME_DRAIN_CTRL -- requirements
Module: frame_drain_ctrl

Interface
REQ-001 SHALL have parameter pADDR_W, default 11, packet-memory address width.
REQ-002 SHALL have parameter pMAX_LEN, default 1518, largest legal frame length in bytes.
REQ-003 SHALL have parameter pIFG, default 12, GAP-state length in clock cycles.
REQ-004 SHALL have port iclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port i_desc_empty, input, 1, descriptor FIFO empty.
REQ-007 SHALL have port i_desc_addr, input, pADDR_W, first-byte address; show-ahead, valid while i_desc_empty=0.
REQ-008 SHALL have port i_desc_len, input, 11, frame byte count; show-ahead, valid while i_desc_empty=0.
REQ-009 SHALL have port o_desc_rd, output, 1, one-cycle descriptor pop.
REQ-010 SHALL have port o_mem_rd, output, 1, packet-memory read strobe.
REQ-011 SHALL have port o_mem_addr, output, pADDR_W, packet-memory read address.
REQ-012 SHALL have port i_mem_data, input, 8, read data, valid exactly 1 cycle after o_mem_rd.
REQ-013 SHALL have port i_pause, input, 1, inhibit start of a new frame.
REQ-014 SHALL have port o_tx_en, output, 1, GMII-style transmit-data valid.
REQ-015 SHALL have port o_tx_d, output, 8, transmit byte.
REQ-016 SHALL have port o_busy, output, 1, frame in progress.
REQ-017 SHALL have port o_frame_cnt, output, 16, frames fully sent.
REQ-018 SHALL have port o_drop_cnt, output, 16, descriptors discarded as illegal.

Function
REQ-019 SHALL implement states IDLE, READ, GAP.
REQ-020 In IDLE with i_desc_empty=0 and i_pause=0, SHALL assert o_desc_rd for that cycle and latch i_desc_addr and i_desc_len the same cycle.
REQ-021 In IDLE with i_desc_empty=1 or i_pause=1, SHALL hold o_desc_rd=0 and stay in IDLE.
REQ-022 On a pop with latched length 0 or >pMAX_LEN, SHALL increment o_drop_cnt, issue no memory reads, and stay in IDLE (next pop possible the following cycle).
REQ-023 On a pop with legal length, SHALL enter READ on the next cycle.
REQ-024 In READ, SHALL assert o_mem_rd every cycle, with o_mem_addr = start address + byte index, modulo 2^pADDR_W (wrap from 2^pADDR_W-1 to 0).
REQ-025 SHALL issue exactly len reads, then enter GAP the cycle after the last read.
REQ-026 SHALL register i_mem_data into o_tx_d and the delayed read strobe into o_tx_en; o_tx_en/o_tx_d for read cycle N appear at cycle N+2.
REQ-027 SHALL never deassert o_tx_en inside a frame; i_pause is sampled only in IDLE.
REQ-028 SHALL hold o_tx_d at 0 whenever o_tx_en=0.
REQ-029 GAP SHALL last exactly pIFG cycles, then return to IDLE; back-to-back frames therefore show exactly pIFG+1 idle cycles on o_tx_en.
REQ-030 SHALL increment o_frame_cnt once per legal frame, in the cycle its last byte appears on o_tx_en.
REQ-031 o_frame_cnt and o_drop_cnt SHALL wrap from 16'hFFFF to 0.
REQ-032 o_busy SHALL be 1 when the state is not IDLE or a read is still in the output pipeline; else 0.

Reset
REQ-033 While i_rst=1 at a rising edge, SHALL force IDLE and clear both counters and all output registers.
REQ-034 After reset, o_desc_rd, o_mem_rd, o_tx_en, o_busy SHALL be 0 and o_tx_d, o_mem_addr 0.
REQ-035 Reset mid-frame SHALL deassert o_tx_en at the next edge and flush the pipeline; the popped descriptor is lost, not re-queued, and no count changes.
REQ-036 i_rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-037 Descriptor addr=0x010, len=64, memory byte k = k: o_desc_rd 1 cycle, 64 reads 0x010..0x04F, o_tx_en 64 cycles carrying 0x00..0x3F, o_frame_cnt=1.
REQ-038 Two queued descriptors len=60 each: exactly 13 idle o_tx_en cycles (pIFG=12) between frames, o_frame_cnt=2.
REQ-039 Descriptor addr=0x7FE, len=4: o_mem_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
REQ-040 Descriptors len=0, len=1600, then len=60: o_drop_cnt=2, no reads for the first two, third frame sent normally.
REQ-041 i_pause=1 with FIFO non-empty: no pop; i_pause asserted mid-frame: frame completes all bytes.
REQ-042 i_rst pulse at byte 20 of a 100-byte frame: o_tx_en=0 next cycle, counters 0, next descriptor starts cleanly.
